sudoku_key_decoder: RTL and testbench
=====================================

// Module: sudoku_key_decoder
// PURPOSE
//  Upstream of the grid/number draw logic. Converts the PS/2 set-2 byte stream into one-cycle-decided
//  Sudoku commands (move cursor, enter digit 1-9, clear cell), tracks cursor row/col on the 9x9 grid, and
//  supplies the cell's top-left pixel (160x120 frame). The draw stage consumes commands via valid/ready.
// PARAMETERS
//  X_ORIGIN    8'd30  pixel x of cell (0,0)
//  Y_ORIGIN    7'd10  pixel y of cell (0,0)
//  CELL_PITCH  4'd11  pixel pitch between cells, both axes
//  GRID_N      9      cells per row/column; cursor range 0..GRID_N-1
// PORTS
//  clock        in   1  system clock (50 MHz)
//  resetn       in   1  asynchronous, active-low reset
//  ps2_byte     in   8  received PS/2 byte
//  ps2_byte_en  in   1  ps2_byte valid this cycle (single-cycle strobe)
//  cmd_ready    in   1  draw stage accepts the command this cycle
//  cmd_valid    out  1  command pending; held until cmd_ready
//  cmd_type     out  2  00 MOVE, 01 DIGIT, 10 CLEAR (11 unused)
//  move         out  3  001 UP, 010 DOWN, 100 LEFT, 111 RIGHT; 000 when cmd_type!=MOVE
//  number       out  4  1..9 for DIGIT, 0 otherwise
//  cursor_row   out  4  current row 0..8
//  cursor_col   out  4  current col 0..8
//  cell_x       out  8  X_ORIGIN + CELL_PITCH*cursor_col
//  cell_y       out  7  Y_ORIGIN + CELL_PITCH*cursor_row
//  overrun      out  1  one-cycle pulse: command-producing make code dropped while cmd_valid&&!cmd_ready
// BEHAVIOUR
//  Reset (async assert, sync-to-clock deassert use): all outputs 0 except cell_x=X_ORIGIN, cell_y=Y_ORIGIN;
//   prefix FSM -> IDLE. Reset mid-command drops the pending command with no handshake.
//  Prefix FSM, advances only on ps2_byte_en:
//   IDLE:     E0->EXT; F0->BRK; else decode plain make code, stay IDLE.
//   EXT:      F0->EXT_BRK; E0->EXT; else decode extended make code, ->IDLE.
//   BRK:      any byte ->IDLE (break discarded). EXT_BRK: any byte ->IDLE.
//  Plain codes: 16,1E,26,25,2E,36,3D,3E,46 -> DIGIT 1..9; 66 (Backspace) -> CLEAR. Others ignored.
//  Extended codes: 75 UP, 72 DOWN, 6B LEFT, 74 RIGHT. Other extended codes ignored. Un-prefixed
//   keypad codes (75/72/6B/74 without E0) ignored.
//  Latency: decoding byte accepted at edge N -> cmd_valid, cmd fields, cursor_*, cell_* all updated at N+1
//   (cell_x/y registered from next-cursor value, never one cycle stale).
//  MOVE: UP row-1, DOWN row+1, LEFT col-1, RIGHT col+1. At edge (e.g. UP at row 0, RIGHT at col 8)
//   cursor unchanged and NO command issued, no overrun. No wrap-around.
//  DIGIT/CLEAR: cursor unchanged; command carries current cell_x/cell_y.
//  Handshake: cmd_valid stays high, fields stable, until edge with cmd_ready=1; deasserts next cycle.
//   cmd_ready while !cmd_valid ignored. Command-producing make code arriving while cmd_valid&&!cmd_ready:
//   dropped, cursor NOT moved, overrun pulses 1 cycle. Same-cycle cmd_ready and new make code: accept
//   old, load new; cmd_valid stays high, no overrun.
//  Typematic repeats (repeated make codes) each produce a command. Prefix FSM runs regardless of cmd_valid.
//  Arithmetic: CELL_PITCH*col fits 8 bits (max 30+88=118), row fits 7 bits (max 98); no saturation.
// TESTING
//  Reset then E0,74 with cmd_ready=1 -> cmd_valid 1 cycle, move=111, col=1, cell_x=41, cell_y=10.
//  From (0,0): E0,75 and E0,6B -> no cmd_valid, cursor stays (0,0); 9x E0,72 -> row 8, 8 cmds, cell_y=98.
//  Byte 2E, cmd_ready=0 for 5 cycles -> cmd_valid held, cmd_type=01, number=5; then 3D -> overrun pulse,
//   fields still number=5; cmd_ready=1 -> cmd_valid low next cycle.
//  Break sequences F0,16 and E0,F0,74 -> no command, cursor unchanged, FSM back in IDLE (next 16 -> digit 1).
//  Byte 66 at (3,4) -> cmd_type=10, number=0, cell_x=74, cell_y=43.
//  resetn low mid-pending command (after E0,72) -> all outputs reset immediately, cell_x=30, cell_y=10.

Source files
------------

// File: rtl/sudoku_key_decoder.sv
// Sudoku keyboard front end: turns a PS/2 set-2 byte stream into MOVE/DIGIT/CLEAR commands,
// keeps the 9x9 cursor position and the matching top-left pixel of the selected cell.
module sudoku_key_decoder #(
  parameter logic [7:0] X_ORIGIN   = 8'd30,
  parameter logic [6:0] Y_ORIGIN   = 7'd10,
  parameter logic [3:0] CELL_PITCH = 4'd11,
  parameter int unsigned GRID_N    = 9
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_byte_en,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [1:0] cmd_type,
  output logic [2:0] move,
  output logic [3:0] number,
  output logic [3:0] cursor_row,
  output logic [3:0] cursor_col,
  output logic [7:0] cell_x,
  output logic [6:0] cell_y,
  output logic       overrun
);

  localparam logic [1:0] CmdMove  = 2'b00;
  localparam logic [1:0] CmdDigit = 2'b01;
  localparam logic [1:0] CmdClear = 2'b10;

  localparam logic [2:0] MvNone  = 3'b000;
  localparam logic [2:0] MvUp    = 3'b001;
  localparam logic [2:0] MvDown  = 3'b010;
  localparam logic [2:0] MvLeft  = 3'b100;
  localparam logic [2:0] MvRight = 3'b111;

  localparam logic [3:0] LastIdx = 4'(GRID_N - 1);

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

  state_e     state_q, state_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic [1:0] cmd_type_q, cmd_type_d;
  logic [2:0] move_q, move_d;
  logic [3:0] number_q, number_d;
  logic [3:0] row_q, row_d;
  logic [3:0] col_q, col_d;
  logic [7:0] cell_x_q, cell_x_d;
  logic [6:0] cell_y_q, cell_y_d;
  logic       overrun_q, overrun_d;

  // Decoded candidate command for the byte presented this cycle
  logic       hit;
  logic [1:0] dec_type;
  logic [2:0] dec_move;
  logic [3:0] dec_num;
  logic [3:0] row_n, col_n;

  // Prefix FSM and make-code decode; a move off the grid edge produces no command at all
  always_comb begin
    state_d  = state_q;
    hit      = 1'b0;
    dec_type = CmdMove;
    dec_move = MvNone;
    dec_num  = 4'd0;
    row_n    = row_q;
    col_n    = col_q;
    if (ps2_byte_en) begin
      unique case (state_q)
        StIdle: begin
          if (ps2_byte == 8'hE0) begin
            state_d = StExt;
          end else if (ps2_byte == 8'hF0) begin
            state_d = StBrk;
          end else begin
            case (ps2_byte)
              8'h16:   dec_num = 4'd1;
              8'h1E:   dec_num = 4'd2;
              8'h26:   dec_num = 4'd3;
              8'h25:   dec_num = 4'd4;
              8'h2E:   dec_num = 4'd5;
              8'h36:   dec_num = 4'd6;
              8'h3D:   dec_num = 4'd7;
              8'h3E:   dec_num = 4'd8;
              8'h46:   dec_num = 4'd9;
              default: dec_num = 4'd0;
            endcase
            if (dec_num != 4'd0) begin
              hit      = 1'b1;
              dec_type = CmdDigit;
            end else if (ps2_byte == 8'h66) begin
              hit      = 1'b1;
              dec_type = CmdClear;
            end
          end
        end
        StExt: begin
          if (ps2_byte == 8'hF0) begin
            state_d = StExtBrk;
          end else if (ps2_byte == 8'hE0) begin
            state_d = StExt;
          end else begin
            state_d = StIdle;
            case (ps2_byte)
              8'h75: if (row_q != 4'd0) begin
                hit = 1'b1; dec_move = MvUp;    row_n = row_q - 4'd1;
              end
              8'h72: if (row_q != LastIdx) begin
                hit = 1'b1; dec_move = MvDown;  row_n = row_q + 4'd1;
              end
              8'h6B: if (col_q != 4'd0) begin
                hit = 1'b1; dec_move = MvLeft;  col_n = col_q - 4'd1;
              end
              8'h74: if (col_q != LastIdx) begin
                hit = 1'b1; dec_move = MvRight; col_n = col_q + 4'd1;
              end
              default: ;
            endcase
          end
        end
        StBrk, StExtBrk: state_d = StIdle;
        default:         state_d = StIdle;
      endcase
    end
  end

  // Command handshake: a new command loads only when the slot is free or being freed this cycle
  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_type_d  = cmd_type_q;
    move_d      = move_q;
    number_d    = number_q;
    row_d       = row_q;
    col_d       = col_q;
    overrun_d   = 1'b0;
    if (cmd_ready) begin
      cmd_valid_d = 1'b0;
    end
    if (hit) begin
      if (!cmd_valid_q || cmd_ready) begin
        cmd_valid_d = 1'b1;
        cmd_type_d  = dec_type;
        move_d      = dec_move;
        number_d    = dec_num;
        row_d       = row_n;
        col_d       = col_n;
      end else begin
        overrun_d = 1'b1;
      end
    end
    // Pixel position follows the next cursor so it is never a cycle behind
    cell_x_d = X_ORIGIN + ({4'd0, col_d} * {4'd0, CELL_PITCH});
    cell_y_d = Y_ORIGIN + ({3'd0, row_d} * {3'd0, CELL_PITCH});
  end

  // State registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= CmdMove;
      move_q      <= MvNone;
      number_q    <= 4'd0;
      row_q       <= 4'd0;
      col_q       <= 4'd0;
      cell_x_q    <= X_ORIGIN;
      cell_y_q    <= Y_ORIGIN;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q  <= cmd_type_d;
      move_q      <= move_d;
      number_q    <= number_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cell_x_q    <= cell_x_d;
      cell_y_q    <= cell_y_d;
      overrun_q   <= overrun_d;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_type   = cmd_type_q;
  assign move       = move_q;
  assign number     = number_q;
  assign cursor_row = row_q;
  assign cursor_col = col_q;
  assign cell_x     = cell_x_q;
  assign cell_y     = cell_y_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sudoku_key_decoder.sv
// Directed bench for sudoku_key_decoder; inputs change and outputs are sampled on the falling edge.
module tb_sudoku_key_decoder;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] ps2_byte = 8'h00;
  logic       ps2_byte_en = 1'b0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [1:0] cmd_type;
  logic [2:0] move;
  logic [3:0] number;
  logic [3:0] cursor_row;
  logic [3:0] cursor_col;
  logic [7:0] cell_x;
  logic [6:0] cell_y;
  logic       overrun;

  int n_checks = 0;
  int n_fails  = 0;
  int n_cmds;

  sudoku_key_decoder dut (
    .clock       (clock),
    .resetn      (resetn),
    .ps2_byte    (ps2_byte),
    .ps2_byte_en (ps2_byte_en),
    .cmd_ready   (cmd_ready),
    .cmd_valid   (cmd_valid),
    .cmd_type    (cmd_type),
    .move        (move),
    .number      (number),
    .cursor_row  (cursor_row),
    .cursor_col  (cursor_col),
    .cell_x      (cell_x),
    .cell_y      (cell_y),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the next falling edge, after the byte was taken
  task automatic send_byte(input logic [7:0] b);
    ps2_byte    = b;
    ps2_byte_en = 1'b1;
    @(negedge clock);
    ps2_byte_en = 1'b0;
  endtask

  task automatic do_reset();
    resetn      = 1'b0;
    ps2_byte_en = 1'b0;
    cmd_ready   = 1'b0;
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    // Reset values
    resetn = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("rst_valid", cmd_valid, 0);
    check("rst_type", cmd_type, 0);
    check("rst_move", move, 0);
    check("rst_num", number, 0);
    check("rst_row", cursor_row, 0);
    check("rst_col", cursor_col, 0);
    check("rst_cx", cell_x, 30);
    check("rst_cy", cell_y, 10);
    check("rst_ovr", overrun, 0);
    resetn = 1'b1;
    @(negedge clock);

    // RIGHT from (0,0)
    cmd_ready = 1'b1;
    send_byte(8'hE0);
    check("e0_novalid", cmd_valid, 0);
    send_byte(8'h74);
    check("right_valid", cmd_valid, 1);
    check("right_type", cmd_type, 0);
    check("right_move", move, 7);
    check("right_col", cursor_col, 1);
    check("right_cx", cell_x, 41);
    check("right_cy", cell_y, 10);
    @(negedge clock);
    check("right_drop", cmd_valid, 0);

    // Edge moves at (0,0) do nothing
    do_reset();
    cmd_ready = 1'b1;
    send_byte(8'hE0);
    send_byte(8'h75);
    check("up_edge_valid", cmd_valid, 0);
    check("up_edge_row", cursor_row, 0);
    send_byte(8'hE0);
    send_byte(8'h6B);
    check("left_edge_valid", cmd_valid, 0);
    check("left_edge_col", cursor_col, 0);
    check("left_edge_ovr", overrun, 0);
    // Un-prefixed keypad code is not a move
    send_byte(8'h72);
    check("plain72_valid", cmd_valid, 0);
    check("plain72_row", cursor_row, 0);

    // Nine DOWN presses stop at row 8 after eight commands
    n_cmds = 0;
    for (int i = 0; i < 9; i++) begin
      send_byte(8'hE0);
      send_byte(8'h72);
      if (cmd_valid) n_cmds++;
    end
    check("down_cmds", n_cmds, 8);
    check("down_row", cursor_row, 8);
    check("down_cy", cell_y, 98);

    // Digit held without ready, then overrun
    @(negedge clock);
    cmd_ready = 1'b0;
    send_byte(8'h2E);
    check("d5_valid", cmd_valid, 1);
    check("d5_type", cmd_type, 1);
    check("d5_num", number, 5);
    check("d5_move", move, 0);
    repeat (5) @(negedge clock);
    check("d5_hold_valid", cmd_valid, 1);
    check("d5_hold_num", number, 5);
    send_byte(8'h3D);
    check("ovr_pulse", overrun, 1);
    check("ovr_num", number, 5);
    check("ovr_row", cursor_row, 8);
    @(negedge clock);
    check("ovr_clear", overrun, 0);
    cmd_ready = 1'b1;
    @(negedge clock);
    check("d5_accept", cmd_valid, 0);

    // Break sequences are discarded and the FSM returns to idle
    send_byte(8'hF0);
    send_byte(8'h16);
    check("brk_valid", cmd_valid, 0);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h74);
    check("ebrk_valid", cmd_valid, 0);
    check("ebrk_col", cursor_col, 0);
    send_byte(8'h16);
    check("post_brk_valid", cmd_valid, 1);
    check("post_brk_num", number, 1);

    // Same-cycle accept and new make code
    cmd_ready = 1'b0;
    @(negedge clock);
    check("hold1_valid", cmd_valid, 1);
    cmd_ready = 1'b1;
    send_byte(8'h1E);
    check("swap_valid", cmd_valid, 1);
    check("swap_num", number, 2);
    check("swap_ovr", overrun, 0);

    // CLEAR at (3,4)
    do_reset();
    cmd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_byte(8'hE0);
      send_byte(8'h72);
    end
    for (int i = 0; i < 4; i++) begin
      send_byte(8'hE0);
      send_byte(8'h74);
    end
    send_byte(8'h66);
    check("clr_valid", cmd_valid, 1);
    check("clr_type", cmd_type, 2);
    check("clr_num", number, 0);
    check("clr_move", move, 0);
    check("clr_cx", cell_x, 74);
    check("clr_cy", cell_y, 43);

    // Async reset while a command is pending
    @(negedge clock);
    cmd_ready = 1'b0;
    send_byte(8'hE0);
    send_byte(8'h72);
    check("pend_valid", cmd_valid, 1);
    check("pend_row", cursor_row, 4);
    #2 resetn = 1'b0;
    #1;
    check("arst_valid", cmd_valid, 0);
    check("arst_row", cursor_row, 0);
    check("arst_col", cursor_col, 0);
    check("arst_cx", cell_x, 30);
    check("arst_cy", cell_y, 10);
    check("arst_type", cmd_type, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
